// File: rtl/prach_hb5_up.sv
// 2x half-band PRACH interpolator over NUM_CHANNEL_USED TDM channels: one input beat yields
// the FIR phase (dout_dp1) and the centre-tap phase (dout_dp2) LATENCY cycles later.
module prach_hb5_up #(
    parameter int NUM_CHANNEL_USED = 48,
    parameter int LATENCY          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] din_dq,
    input  logic               din_dv,
    input  logic [7:0]         din_chn,
    input  logic               sync_in,
    output logic signed [15:0] dout_dp1,
    output logic signed [15:0] dout_dp2,
    output logic               dout_dv,
    output logic [7:0]         dout_chn,
    output logic               sync_out
);

    localparam int SL_LEN      = 7 * NUM_CHANNEL_USED + 1;
    localparam int PRIME_BEATS = 7 * NUM_CHANNEL_USED;
    localparam int CW          = $clog2(PRIME_BEATS + 1);
    localparam logic [CW-1:0] PRIME_MAX = CW'(PRIME_BEATS);
    // Stages 5..LATENCY-1 carry finished results; LATENCY must be at least 6.
    localparam int DLY = LATENCY - 5;

    function automatic logic signed [17:0] coef_f(input int k);
        case (k)
            0:       coef_f = -18'sd616;
            1:       coef_f = 18'sd2989;
            2:       coef_f = -18'sd9818;
            3:       coef_f = 18'sd40178;
            default: coef_f = 18'sd0;
        endcase
    endfunction

    // Round half up at bit 16, then clamp to the 16-bit signed range.
    function automatic logic signed [15:0] round_sat_f(input logic signed [36:0] acc);
        logic signed [37:0] biased;
        logic signed [21:0] shifted;
        biased  = 38'(acc) + 38'sd32768;
        shifted = biased[37:16];
        if (shifted > 22'sd32767) begin
            round_sat_f = 16'sh7fff;
        end else if (shifted < -22'sd32768) begin
            round_sat_f = 16'sh8000;
        end else begin
            round_sat_f = shifted[15:0];
        end
    endfunction

    logic signed [15:0] sl_q [0:SL_LEN-1];
    logic [CW-1:0]      cnt_q, cnt_d, cnt_base_s;
    logic               prime_ok_s;
    logic [LATENCY-1:0] dv_pipe_q, sync_pipe_q, ok_pipe_q;
    logic [7:0]         chn_pipe_q [0:LATENCY-1];
    logic signed [16:0] pre_q  [0:3];
    logic signed [34:0] prod_q [0:3];
    logic signed [36:0] acc_q;
    logic signed [15:0] ctr2_q, ctr3_q, ctr4_q;
    logic signed [15:0] p1_dly_q [0:DLY-1];
    logic signed [15:0] p2_dly_q [0:DLY-1];

    // Newest sample enters the shift line only on a valid beat.
    always_ff @(posedge clk) begin
        if (din_dv) begin
            sl_q[0] <= din_dq;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SL_LEN; gi++) begin : g_sl
            // Shift line cell; tap k of the current channel sits at k*NUM_CHANNEL_USED.
            always_ff @(posedge clk) begin
                if (din_dv) begin
                    sl_q[gi] <= sl_q[gi-1];
                end
            end
        end
    endgenerate

    // A sync on the same cycle as a beat makes that beat number 0 of the new window.
    always_comb begin
        cnt_base_s = sync_in ? '0 : cnt_q;
        prime_ok_s = (cnt_base_s == PRIME_MAX);
        if (din_dv && !prime_ok_s) begin
            cnt_d = cnt_base_s + CW'(1);
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // Priming counter and control delay lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dv_pipe_q   <= '0;
            sync_pipe_q <= '0;
            ok_pipe_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dv_pipe_q   <= {dv_pipe_q[LATENCY-2:0], din_dv};
            sync_pipe_q <= {sync_pipe_q[LATENCY-2:0], sync_in};
            ok_pipe_q   <= {ok_pipe_q[LATENCY-2:0], prime_ok_s};
        end
    end

    // Channel tag delay line head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chn_pipe_q[0] <= 8'd0;
        end else begin
            chn_pipe_q[0] <= din_chn;
        end
    end

    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_chn
            // Channel tag delay line cell.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chn_pipe_q[gi] <= 8'd0;
                end else begin
                    chn_pipe_q[gi] <= chn_pipe_q[gi-1];
                end
            end
        end

        for (gi = 0; gi < 4; gi++) begin : g_tap
            // Symmetric pre-add and full-precision product per coefficient.
            always_ff @(posedge clk) begin
                pre_q[gi]  <= 17'(sl_q[gi * NUM_CHANNEL_USED]) + 17'(sl_q[(7 - gi) * NUM_CHANNEL_USED]);
                prod_q[gi] <= 35'(pre_q[gi]) * 35'(coef_f(gi));
            end
        end

        for (gi = 1; gi < DLY; gi++) begin : g_dly
            // Result alignment stages up to the output register.
            always_ff @(posedge clk) begin
                p1_dly_q[gi] <= p1_dly_q[gi-1];
                p2_dly_q[gi] <= p2_dly_q[gi-1];
            end
        end
    endgenerate

    // Accumulate, round/saturate and carry the centre tap alongside.
    always_ff @(posedge clk) begin
        acc_q       <= 37'(prod_q[0]) + 37'(prod_q[1]) + 37'(prod_q[2]) + 37'(prod_q[3]);
        ctr2_q      <= sl_q[3 * NUM_CHANNEL_USED];
        ctr3_q      <= ctr2_q;
        ctr4_q      <= ctr3_q;
        p1_dly_q[0] <= round_sat_f(acc_q);
        p2_dly_q[0] <= ctr4_q;
    end

    // Sample outputs update only on valid beats; beats inside the priming window emit zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dp1 <= 16'sd0;
            dout_dp2 <= 16'sd0;
        end else if (dv_pipe_q[LATENCY-2]) begin
            if (ok_pipe_q[LATENCY-2]) begin
                dout_dp1 <= p1_dly_q[DLY-1];
                dout_dp2 <= p2_dly_q[DLY-1];
            end else begin
                dout_dp1 <= 16'sd0;
                dout_dp2 <= 16'sd0;
            end
        end else begin
            dout_dp1 <= dout_dp1;
            dout_dp2 <= dout_dp2;
        end
    end

    assign dout_dv  = dv_pipe_q[LATENCY-1];
    assign sync_out = sync_pipe_q[LATENCY-1];
    assign dout_chn = chn_pipe_q[LATENCY-1];

endmodule

// File: tb/tb_prach_hb5_up.sv
// Randomized bench for prach_hb5_up against a per-cycle reference model of the
// interpolator, plus directed impulse, DC, saturation and reset scenarios.
module tb_prach_hb5_up;

    localparam int N     = 48;
    localparam int LAT   = 8;
    localparam int PRIME = 7 * N;
    localparam int MAXC  = 20000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] din_dq = 16'sd0;
    logic               din_dv = 1'b0;
    logic [7:0]         din_chn = 8'd0;
    logic               sync_in = 1'b0;
    logic signed [15:0] dout_dp1, dout_dp2;
    logic               dout_dv;
    logic [7:0]         dout_chn;
    logic               sync_out;

    always #5 clk = ~clk;

    prach_hb5_up #(.NUM_CHANNEL_USED(N), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
        .sync_in(sync_in), .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .sync_out(sync_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int since   = 0;
    int chn_rr  = 0;
    int held1   = 0;
    int held2   = 0;
    int last1   = 0;
    int last2   = 0;
    int samp[$];
    bit e_dv[MAXC];
    bit e_sync[MAXC];
    int e_chn[MAXC];
    int e_p1[MAXC];
    int e_p2[MAXC];
    bit cap_on = 1'b0;
    int cap1[$];
    int cap2[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Sample of the current channel k periods back (k=0 is the newest beat).
    function automatic int xs(input int k);
        int idx;
        idx = samp.size() - 1 - k * N;
        return (idx >= 0) ? samp[idx] : 0;
    endfunction

    function automatic int fir_ref();
        int     c[4];
        longint acc;
        longint q;
        c[0] = -616; c[1] = 2989; c[2] = -9818; c[3] = 40178;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(c[k]) * longint'(xs(k) + xs(7 - k));
        q = (acc + 32768) >>> 16;
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (cyc >= MAXC) begin
            $display("FAIL budget: cycle %0d reached, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        chk("dout_dv", dout_dv, e_dv[cyc]);
        chk("dout_chn", dout_chn, e_chn[cyc]);
        chk("sync_out", sync_out, e_sync[cyc]);
        chk("dout_dp1", dout_dp1, e_p1[cyc]);
        chk("dout_dp2", dout_dp2, e_p2[cyc]);
        if (dout_dv) begin
            last1 = dout_dp1;
            last2 = dout_dp2;
            if (cap_on && dout_chn == 8'd0) begin
                cap1.push_back(dout_dp1);
                cap2.push_back(dout_dp2);
            end
        end
        cyc++;
    endtask

    task automatic step(input bit dv, input int data, input bit sync);
        int t;
        din_dv  = dv;
        din_dq  = 16'(data);
        din_chn = dv ? 8'(chn_rr) : 8'd0;
        sync_in = sync;
        if (sync) since = 0;
        if (dv) begin
            samp.push_back(data);
            held1 = (since >= PRIME) ? fir_ref() : 0;
            held2 = (since >= PRIME) ? xs(3) : 0;
            since++;
            chn_rr = (chn_rr + 1) % N;
        end
        t = cyc + LAT - 1;
        if (t < MAXC) begin
            e_dv[t]   = dv;
            e_sync[t] = sync;
            e_chn[t]  = dv ? (chn_rr + N - 1) % N : 0;
            e_p1[t]   = held1;
            e_p2[t]   = held2;
        end
        tick();
    endtask

    function automatic int rnd_sample();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32767;
        if (r == 1) return -32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    int imp_p1[9];
    int imp_p2[9];
    int sat_pat[8];

    initial begin
        imp_p1 = '{-154, 747, -2454, 10045, 10045, -2454, 747, -154, 0};
        imp_p2 = '{0, 0, 0, 16384, 0, 0, 0, 0, 0};
        sat_pat = '{-32767, 32767, -32767, 32767, 32767, -32767, 32767, -32767};

        #2;
        chk("reset_dv", dout_dv, 0);
        chk("reset_dp1", dout_dp1, 0);
        chk("reset_dp2", dout_dp2, 0);
        chk("reset_chn", dout_chn, 0);
        chk("reset_sync", sync_out, 0);
        #1 rst_n = 1'b1;
        idle(10);

        // Random stream with gaps and occasional sync pulses.
        step(1'b1, rnd_sample(), 1'b1);
        for (int b = 1; b < 12 * N; b++) begin
            int gap;
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) step(1'b0, 0, ($urandom_range(0, 299) == 0));
            step(1'b1, rnd_sample(), ($urandom_range(0, 199) == 0));
        end

        // Sync on an idle cycle followed by a gap-free nonzero stream.
        step(1'b0, 0, 1'b1);
        for (int b = 0; b < 9 * N; b++) step(1'b1, rnd_sample(), 1'b0);

        // Reset with beats in flight.
        for (int b = 0; b < 3; b++) step(1'b1, rnd_sample(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dv", dout_dv, 0);
        chk("rst_mid_dp1", dout_dp1, 0);
        chk("rst_mid_dp2", dout_dp2, 0);
        chk("rst_mid_chn", dout_chn, 0);
        chk("rst_mid_sync", sync_out, 0);
        held1 = 0;
        held2 = 0;
        since = 0;
        for (int i = cyc; i < cyc + LAT + 1 && i < MAXC; i++) begin
            e_dv[i] = 1'b0; e_sync[i] = 1'b0; e_chn[i] = 0; e_p1[i] = 0; e_p2[i] = 0;
        end
        idle(2);
        #2 rst_n = 1'b1;
        idle(10);

        // Impulse on channel 0 after a freshly primed window of zeros.
        while (chn_rr != 0) step(1'b1, 0, 1'b0);
        idle(10);
        cap1.delete();
        cap2.delete();
        cap_on = 1'b1;
        step(1'b1, 0, 1'b1);
        for (int b = 1; b < PRIME; b++) step(1'b1, 0, 1'b0);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < N; c++) step(1'b1, (r == 0 && c == 0) ? 16384 : 0, 1'b0);
        idle(10);
        cap_on = 1'b0;
        chk("imp_count", cap1.size(), 16);
        if (cap1.size() == 16) begin
            chk("imp_primed_dp1", cap1[6], 0);
            for (int i = 0; i < 9; i++) begin
                chk("imp_dp1", cap1[7 + i], imp_p1[i]);
                chk("imp_dp2", cap2[7 + i], imp_p2[i]);
            end
        end

        // DC at full scale on every channel.
        for (int b = 0; b < 8 * N; b++) step(1'b1, 32767, 1'b0);
        idle(10);
        chk("dc_dp1", last1, 32732);
        chk("dc_dp2", last2, 32767);

        // Alternating full-scale pattern on channel 0 drives the FIR phase into saturation.
        cap1.delete();
        cap2.delete();
        cap_on = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++) begin
                int gap;
                gap = int'($urandom_range(0, 5));
                for (int g = 0; g < gap; g++) step(1'b0, 0, 1'b0);
                step(1'b1, (c == 0) ? sat_pat[r] : 0, 1'b0);
            end
        end
        idle(10);
        cap_on = 1'b0;
        chk("sat_count", cap1.size(), 8);
        if (cap1.size() == 8) chk("sat_dp1", cap1[7], 32767);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
